// File: rtl/dsm_pkg.sv
// Shared definitions for the I2S receiver that feeds the dual-channel
// sigma-delta modulator.
//   - default sample width and slot length
//   - FSM state encoding (IDLE, LEFT, RIGHT)
//   - width of the per-slot bit counter, which must be able to hold SLOT_W
package dsm_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int SLOT_W_DEF = 32;

    // The counter saturates at SLOT_W, so it needs room for that value itself.
    localparam int CNT_W = $clog2(SLOT_W_DEF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } dsm_state_e;

    // Counter width for a non-default slot length.
    function automatic int dsm_cnt_w(input int slot_w);
        return $clog2(slot_w + 1);
    endfunction

endpackage

// File: rtl/dsm_i2s_rx_if.sv
// Bundle of the serial audio inputs, controls and parallel sample outputs of
// dsm_i2s_rx.
//   master : drives i2s_bclk/i2s_lrck/i2s_sdata, exchangeLR, err_clr and
//            observes dsm_chan1/dsm_chan2, sample_valid, frame_err, locked
//   slave  : the receiver side (the opposite directions)
interface dsm_i2s_rx_if
    import dsm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              i2s_bclk;
    logic              i2s_lrck;
    logic              i2s_sdata;
    logic              exchangeLR;
    logic              err_clr;
    logic [DATA_W-1:0] dsm_chan1;
    logic [DATA_W-1:0] dsm_chan2;
    logic              sample_valid;
    logic              frame_err;
    logic              locked;

    modport master (
        output i2s_bclk, i2s_lrck, i2s_sdata, exchangeLR, err_clr,
        input  dsm_chan1, dsm_chan2, sample_valid, frame_err, locked
    );

    modport slave (
        input  i2s_bclk, i2s_lrck, i2s_sdata, exchangeLR, err_clr,
        output dsm_chan1, dsm_chan2, sample_valid, frame_err, locked
    );
endinterface

// File: rtl/dsm_sync_edge.sv
// Synchronizer for the asynchronous serial inputs plus rising-edge detect on
// the clock-like input.
//   clk, rst_n : receiving clock, asynchronous active-low reset
//   edge_i     : signal whose rising edge is detected (BCLK)
//   data_i     : companion signals synchronized at the same depth (LRCK, SDATA)
//   rise_o     : registered one-cycle pulse per rising edge of edge_i
//   data_o     : data_i, registered so it is aligned with rise_o
module dsm_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int W           = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         edge_i,
    input  logic [W-1:0] data_i,
    output logic         rise_o,
    output logic [W-1:0] data_o
);
    // Bit 0 of every stage carries edge_i, bits W:1 carry data_i, so all
    // inputs see exactly the same synchronizer latency.
    logic [SYNC_STAGES-1:0][W:0] stage_q, stage_d;
    logic                        dly_q, dly_d;
    logic                        rise_q, rise_d;
    logic [W-1:0]                data_q, data_d;

    // Next-state of the synchronizer chain, edge delay and aligned outputs.
    always_comb begin
        stage_d[0] = {data_i, edge_i};
        for (int k = 1; k < SYNC_STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
        dly_d  = stage_q[SYNC_STAGES-1][0];
        rise_d = stage_q[SYNC_STAGES-1][0] & ~dly_q;
        data_d = stage_q[SYNC_STAGES-1][W:1];
    end

    // Synchronizer and edge-detect flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            dly_q   <= 1'b0;
            rise_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            stage_q <= stage_d;
            dly_q   <= dly_d;
            rise_q  <= rise_d;
            data_q  <= data_d;
        end
    end

    assign rise_o = rise_q;
    assign data_o = data_q;

endmodule

// File: rtl/dsm_i2s_rx.sv
// I2S receiver feeding the sigma-delta modulator's parallel inputs.
// Oversamples BCLK/LRCK/SDATA on mclk512, frames left/right slots, and emits
// one DATA_W-bit stereo pair per frame with optional channel swap.
//   mclk512 : system clock (512 fs)
//   reset   : asynchronous active-low reset
//   bus     : serial inputs, exchangeLR, err_clr in; dsm_chan1/2,
//             sample_valid, frame_err, locked out (all outputs registered)
module dsm_i2s_rx
    import dsm_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SLOT_W      = SLOT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic            mclk512,
    input  logic            reset,
    dsm_i2s_rx_if.slave     bus
);
    localparam int CW = dsm_cnt_w(SLOT_W);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_LEFT  = LEFT;
    localparam logic [1:0] S_RIGHT = RIGHT;

    logic              rise_s;
    logic [1:0]        sdat_s;
    logic              lrck_s;
    logic              sdata_s;

    logic [1:0]        state_q, state_d;
    logic              lrck_prev_q, lrck_prev_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              upd_q, upd_d;
    logic [DATA_W-1:0] chan1_q, chan1_d;
    logic [DATA_W-1:0] chan2_q, chan2_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              locked_q, locked_d;

    logic [DATA_W-1:0] shift_nxt_s;
    logic              boundary_s;
    logic              slot_ok_s;
    logic              set_err_s;
    logic              clr_lock_s;

    dsm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .W           (2)
    ) u_sync (
        .clk    (mclk512),
        .rst_n  (reset),
        .edge_i (bus.i2s_bclk),
        .data_i ({bus.i2s_sdata, bus.i2s_lrck}),
        .rise_o (rise_s),
        .data_o (sdat_s)
    );

    assign lrck_s  = sdat_s[0];
    assign sdata_s = sdat_s[1];

    // Slot framing, shift capture and FSM; the final bit of a slot arrives
    // on the same BCLK rise that reveals the LRCK change, so the word closed
    // at a boundary includes that bit when it still falls inside DATA_W.
    always_comb begin
        state_d     = state_q;
        lrck_prev_d = lrck_prev_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        left_d      = left_q;
        right_d     = right_q;
        upd_d       = 1'b0;
        set_err_s   = 1'b0;
        clr_lock_s  = 1'b0;

        if (bit_cnt_q < CW'(DATA_W)) begin
            shift_nxt_s = {shift_q[DATA_W-2:0], sdata_s};
        end else begin
            shift_nxt_s = shift_q;
        end
        boundary_s = (lrck_s != lrck_prev_q);
        slot_ok_s  = (({1'b0, bit_cnt_q} + {{CW{1'b0}}, 1'b1}) == (CW+1)'(SLOT_W));

        if (rise_s) begin
            lrck_prev_d = lrck_s;
            if (boundary_s) begin
                bit_cnt_d = '0;
                shift_d   = '0;
                case (state_q)
                    S_IDLE: begin
                        if (!lrck_s) begin
                            state_d = S_LEFT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    S_LEFT: begin
                        if (lrck_s && slot_ok_s) begin
                            left_d  = shift_nxt_s;
                            state_d = S_RIGHT;
                        end else begin
                            set_err_s = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                    S_RIGHT: begin
                        if (!lrck_s && slot_ok_s) begin
                            right_d = shift_nxt_s;
                            upd_d   = 1'b1;
                            state_d = S_LEFT;
                        end else begin
                            set_err_s  = 1'b1;
                            clr_lock_s = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end else begin
                // Saturating count makes an over-long slot fail the length test.
                if (bit_cnt_q == CW'(SLOT_W)) begin
                    bit_cnt_d = bit_cnt_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
                if (state_q != S_IDLE) begin
                    shift_d = shift_nxt_s;
                end else begin
                    shift_d = shift_q;
                end
            end
        end else begin
            state_d = state_q;
        end
    end

    // Output stage: pair update one cycle after the closing boundary, sticky
    // error with set priority over clear, lock indication.
    always_comb begin
        valid_d = upd_q;
        if (upd_q) begin
            if (bus.exchangeLR) begin
                chan1_d = right_q;
                chan2_d = left_q;
            end else begin
                chan1_d = left_q;
                chan2_d = right_q;
            end
        end else begin
            chan1_d = chan1_q;
            chan2_d = chan2_q;
        end

        if (set_err_s) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (upd_q) begin
            locked_d = 1'b1;
        end else if (clr_lock_s) begin
            locked_d = 1'b0;
        end else begin
            locked_d = locked_q;
        end
    end

    // State and output registers.
    always_ff @(posedge mclk512 or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lrck_prev_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            left_q      <= '0;
            right_q     <= '0;
            upd_q       <= 1'b0;
            chan1_q     <= '0;
            chan2_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrck_prev_q <= lrck_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            left_q      <= left_d;
            right_q     <= right_d;
            upd_q       <= upd_d;
            chan1_q     <= chan1_d;
            chan2_q     <= chan2_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
        end
    end

    assign bus.dsm_chan1    = chan1_q;
    assign bus.dsm_chan2    = chan2_q;
    assign bus.sample_valid = valid_q;
    assign bus.frame_err    = err_q;
    assign bus.locked       = locked_q;

endmodule

// File: tb/tb_dsm_i2s_rx.sv
// Directed testbench for dsm_i2s_rx: builds I2S frames bit by bit on a
// mclk512-derived BCLK (8 mclk per bit) and checks outputs against
// hand-computed values.
module tb_dsm_i2s_rx;

    logic mclk512 = 1'b0;
    logic reset   = 1'b0;

    dsm_i2s_rx_if #(.DATA_W(24)) bus ();

    dsm_i2s_rx #(
        .DATA_W      (24),
        .SLOT_W      (32),
        .SYNC_STAGES (2)
    ) dut (
        .mclk512 (mclk512),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 mclk512 = ~mclk512;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sv_cnt = 0;
    int sv_cyc = 0;
    int rise_cyc = 0;

    always @(posedge mclk512) cyc <= cyc + 1;

    // Count sample_valid pulses and note when the latest one appeared.
    always @(negedge mclk512) begin
        if (bus.sample_valid === 1'b1) begin
            sv_cnt <= sv_cnt + 1;
            sv_cyc <= cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One BCLK period: low half with new lrck/sdata, then a rising edge.
    task automatic send_bit(input logic lr, input logic b);
        bus.i2s_bclk  = 1'b0;
        bus.i2s_lrck  = lr;
        bus.i2s_sdata = b;
        repeat (4) @(negedge mclk512);
        bus.i2s_bclk = 1'b1;
        rise_cyc = cyc + 1;
        repeat (4) @(negedge mclk512);
    endtask

    // nbits of a slot, MSB first; the last bit goes out with the next slot's lrck.
    task automatic send_slot(input logic ch, input logic [31:0] w, input int nbits, input logic nxt);
        for (int i = 0; i < nbits; i++) begin
            send_bit((i == nbits - 1) ? nxt : ch, w[31 - i]);
        end
    endtask

    task automatic settle();
        bus.i2s_bclk = 1'b0;
        repeat (8) @(negedge mclk512);
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r, input logic [7:0] pad);
        send_slot(1'b0, {l, pad}, 32, 1'b1);
        send_slot(1'b1, {r, pad}, 32, 1'b0);
        settle();
    endtask

    task automatic test_reset();
        repeat (4) @(negedge mclk512);
        total++; if (bus.dsm_chan1 !== 24'h000000) begin bad++; $display("FAIL rst_chan1 got=%h want=000000", bus.dsm_chan1); end
        total++; if (bus.dsm_chan2 !== 24'h000000) begin bad++; $display("FAIL rst_chan2 got=%h want=000000", bus.dsm_chan2); end
        total++; if (bus.sample_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.sample_valid); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", bus.frame_err); end
        total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b want=0", bus.locked); end
        reset = 1'b1;
        @(negedge mclk512);
    endtask

    task automatic test_nominal();
        int base;
        send_slot(1'b1, 32'h0000_0000, 32, 1'b0);
        settle();
        base = sv_cnt;
        total++; if (sv_cnt !== base || bus.locked !== 1'b0) begin bad++; $display("FAIL nom_prime got cnt=%0d lock=%b want cnt=%0d lock=0", sv_cnt, bus.locked, base); end
        send_pair(24'h123456, 24'hABCDEF, 8'h00);
        total++; if (sv_cnt !== base + 1) begin bad++; $display("FAIL nom_cnt1 got=%0d want=%0d", sv_cnt, base + 1); end
        total++; if (bus.dsm_chan1 !== 24'h123456) begin bad++; $display("FAIL nom_chan1 got=%h want=123456", bus.dsm_chan1); end
        total++; if (bus.dsm_chan2 !== 24'hABCDEF) begin bad++; $display("FAIL nom_chan2 got=%h want=abcdef", bus.dsm_chan2); end
        total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL nom_locked got=%b want=1", bus.locked); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL nom_err got=%b want=0", bus.frame_err); end
        total++; if (sv_cyc - rise_cyc !== 4) begin bad++; $display("FAIL nom_latency got=%0d want=4", sv_cyc - rise_cyc); end
        send_pair(24'h123456, 24'hABCDEF, 8'h00);
        total++; if (sv_cnt !== base + 2) begin bad++; $display("FAIL nom_cnt2 got=%0d want=%0d", sv_cnt, base + 2); end
        total++; if (bus.dsm_chan1 !== 24'h123456 || bus.dsm_chan2 !== 24'hABCDEF) begin bad++; $display("FAIL nom_pair2 got=%h/%h want=123456/abcdef", bus.dsm_chan1, bus.dsm_chan2); end
    endtask

    task automatic test_swap();
        int base;
        base = sv_cnt;
        bus.exchangeLR = 1'b1;
        send_pair(24'h123456, 24'hABCDEF, 8'h00);
        total++; if (sv_cnt !== base + 1) begin bad++; $display("FAIL swap_cnt got=%0d want=%0d", sv_cnt, base + 1); end
        total++; if (bus.dsm_chan1 !== 24'hABCDEF) begin bad++; $display("FAIL swap_chan1 got=%h want=abcdef", bus.dsm_chan1); end
        total++; if (bus.dsm_chan2 !== 24'h123456) begin bad++; $display("FAIL swap_chan2 got=%h want=123456", bus.dsm_chan2); end
        bus.exchangeLR = 1'b0;
    endtask

    task automatic test_full_scale();
        send_pair(24'h800000, 24'h7FFFFF, 8'hFF);
        total++; if (bus.dsm_chan1 !== 24'h800000) begin bad++; $display("FAIL fs_chan1 got=%h want=800000", bus.dsm_chan1); end
        total++; if (bus.dsm_chan2 !== 24'h7FFFFF) begin bad++; $display("FAIL fs_chan2 got=%h want=7fffff", bus.dsm_chan2); end
    endtask

    task automatic test_short_right();
        int base;
        base = sv_cnt;
        send_slot(1'b0, {24'h123456, 8'h00}, 32, 1'b1);
        send_slot(1'b1, {24'hABCDEF, 8'h00}, 31, 1'b0);
        settle();
        total++; if (sv_cnt !== base) begin bad++; $display("FAIL short_cnt got=%0d want=%0d", sv_cnt, base); end
        total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL short_err got=%b want=1", bus.frame_err); end
        total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL short_locked got=%b want=0", bus.locked); end
        total++; if (bus.dsm_chan1 !== 24'h800000) begin bad++; $display("FAIL short_hold got=%h want=800000", bus.dsm_chan1); end
        send_pair(24'h111111, 24'h222222, 8'h00);
        total++; if (sv_cnt !== base) begin bad++; $display("FAIL rec_cnt0 got=%0d want=%0d", sv_cnt, base); end
        send_pair(24'h333333, 24'h444444, 8'h00);
        total++; if (sv_cnt !== base + 1) begin bad++; $display("FAIL rec_cnt1 got=%0d want=%0d", sv_cnt, base + 1); end
        total++; if (bus.dsm_chan1 !== 24'h333333 || bus.dsm_chan2 !== 24'h444444) begin bad++; $display("FAIL rec_pair got=%h/%h want=333333/444444", bus.dsm_chan1, bus.dsm_chan2); end
        total++; if (bus.frame_err !== 1'b1 || bus.locked !== 1'b1) begin bad++; $display("FAIL rec_flags got err=%b lock=%b want err=1 lock=1", bus.frame_err, bus.locked); end
        bus.err_clr = 1'b1;
        @(negedge mclk512);
        bus.err_clr = 1'b0;
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL errclr got=%b want=0", bus.frame_err); end
    endtask

    task automatic test_saturate();
        int base;
        base = sv_cnt;
        send_slot(1'b0, 32'hFFFF_FFFF, 40, 1'b1);
        settle();
        total++; if (bus.frame_err !== 1'b1 || sv_cnt !== base) begin bad++; $display("FAIL sat_err got err=%b cnt=%0d want err=1 cnt=%0d", bus.frame_err, sv_cnt, base); end
        send_slot(1'b1, 32'h0000_0000, 32, 1'b0);
        send_pair(24'hC0FFEE, 24'h0BADF0, 8'h00);
        total++; if (sv_cnt !== base + 1 || bus.dsm_chan1 !== 24'hC0FFEE || bus.dsm_chan2 !== 24'h0BADF0) begin bad++; $display("FAIL sat_rec got cnt=%0d %h/%h want cnt=%0d c0ffee/0badf0", sv_cnt, bus.dsm_chan1, bus.dsm_chan2, base + 1); end
        bus.err_clr = 1'b1;
        @(negedge mclk512);
        bus.err_clr = 1'b0;
    endtask

    task automatic test_lrck_no_bclk();
        int base;
        base = sv_cnt;
        bus.i2s_bclk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.i2s_lrck  = ~bus.i2s_lrck;
            bus.i2s_sdata = ~bus.i2s_sdata;
            repeat (3) @(negedge mclk512);
        end
        total++; if (sv_cnt !== base || bus.frame_err !== 1'b0) begin bad++; $display("FAIL lrck_idle got cnt=%0d err=%b want cnt=%0d err=0", sv_cnt, bus.frame_err, base); end
        send_pair(24'h5A5A5A, 24'hA5A5A5, 8'h00);
        total++; if (sv_cnt !== base + 1 || bus.dsm_chan1 !== 24'h5A5A5A || bus.dsm_chan2 !== 24'hA5A5A5 || bus.frame_err !== 1'b0) begin bad++; $display("FAIL lrck_pair got cnt=%0d %h/%h err=%b want cnt=%0d 5a5a5a/a5a5a5 err=0", sv_cnt, bus.dsm_chan1, bus.dsm_chan2, bus.frame_err, base + 1); end
    endtask

    task automatic test_mid_right();
        int base;
        reset = 1'b0;
        repeat (2) @(negedge mclk512);
        reset = 1'b1;
        @(negedge mclk512);
        base = sv_cnt;
        send_slot(1'b1, 32'hFFFF_FFFF, 10, 1'b0);
        settle();
        total++; if (sv_cnt !== base || bus.locked !== 1'b0) begin bad++; $display("FAIL midr_partial got cnt=%0d lock=%b want cnt=%0d lock=0", sv_cnt, bus.locked, base); end
        send_pair(24'h0F0F0F, 24'hF0F0F0, 8'h00);
        total++; if (sv_cnt !== base + 1) begin bad++; $display("FAIL midr_cnt got=%0d want=%0d", sv_cnt, base + 1); end
        total++; if (bus.dsm_chan1 !== 24'h0F0F0F || bus.dsm_chan2 !== 24'hF0F0F0) begin bad++; $display("FAIL midr_pair got=%h/%h want=0f0f0f/f0f0f0", bus.dsm_chan1, bus.dsm_chan2); end
    endtask

    task automatic test_mid_left_reset();
        int base;
        base = sv_cnt;
        for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.dsm_chan1 !== 24'h000000 || bus.dsm_chan2 !== 24'h000000) begin bad++; $display("FAIL midl_rst_chan got=%h/%h want=000000/000000", bus.dsm_chan1, bus.dsm_chan2); end
        total++; if (bus.locked !== 1'b0 || bus.sample_valid !== 1'b0 || bus.frame_err !== 1'b0) begin bad++; $display("FAIL midl_rst_flags got lock=%b sv=%b err=%b want 0/0/0", bus.locked, bus.sample_valid, bus.frame_err); end
        @(negedge mclk512);
        reset = 1'b1;
        @(negedge mclk512);
        for (int i = 0; i < 22; i++) send_bit((i == 21) ? 1'b1 : 1'b0, 1'b0);
        send_slot(1'b1, 32'h1234_5678, 32, 1'b0);
        settle();
        total++; if (sv_cnt !== base) begin bad++; $display("FAIL midl_nopair got=%0d want=%0d", sv_cnt, base); end
        send_pair(24'h13579B, 24'h2468AC, 8'h00);
        total++; if (sv_cnt !== base + 1) begin bad++; $display("FAIL midl_cnt got=%0d want=%0d", sv_cnt, base + 1); end
        total++; if (bus.dsm_chan1 !== 24'h13579B || bus.dsm_chan2 !== 24'h2468AC) begin bad++; $display("FAIL midl_pair got=%h/%h want=13579b/2468ac", bus.dsm_chan1, bus.dsm_chan2); end
    endtask

    initial begin
        bus.i2s_bclk   = 1'b0;
        bus.i2s_lrck   = 1'b0;
        bus.i2s_sdata  = 1'b0;
        bus.exchangeLR = 1'b0;
        bus.err_clr    = 1'b0;
        test_reset();
        test_nominal();
        test_swap();
        test_full_scale();
        test_short_right();
        test_saturate();
        test_lrck_no_bclk();
        test_mid_right();
        test_mid_left_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsm_i2s_rx.md
Name: dsm_i2s_rx

Overview:
- Serial audio front end that feeds the dual-channel sigma-delta modulator's parallel sample inputs dsm_chan1/dsm_chan2.
- Receives standard I2S (BCLK = 64·fs, LRCK = fs, MSB-first, one-BCLK delay after the LRCK edge) and oversamples it on mclk512 (512·fs, 8 mclk per BCLK).
- Emits one 24-bit two's-complement stereo pair per frame, with an optional L/R swap, plus a frame-error flag.

Parameters:
- DATA_W, 24, output sample width; MSB-aligned bits taken from each slot.
- SLOT_W, 32, BCLK periods per channel slot; must satisfy SLOT_W ≥ DATA_W.
- SYNC_STAGES, 2, synchronizer flops on each serial input.

Ports:
- mclk512  in  1  system clock, 512·fs.
- reset  in  1  asynchronous, active-low reset.
- i2s_bclk  in  1  serial bit clock, asynchronous to mclk512.
- i2s_lrck  in  1  word select: 0 = left slot, 1 = right slot.
- i2s_sdata  in  1  serial data.
- exchangeLR  in  1  1 = swap channels at the output.
- err_clr  in  1  clears frame_err; synchronous; level-sensitive.
- dsm_chan1  out  DATA_W  channel-1 sample (left unless swapped).
- dsm_chan2  out  DATA_W  channel-2 sample (right unless swapped).
- sample_valid  out  1  one-mclk512 pulse when dsm_chan1/2 update.
- frame_err  out  1  sticky slot-length error.
- locked  out  1  1 once a full, error-free L+R pair has been output.

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM → IDLE, counters/shifters 0, synchronizer flops 0.
- Input conditioning:
  - Each of bclk, lrck and sdata passes through SYNC_STAGES flops.
  - bclk rise is detected from the synced value vs. a 1-flop delay.
  - All slot logic advances only on a bclk_rise cycle. lrck and sdata are sampled from the same synchronizer depth as bclk.
- Slot boundary: at a bclk_rise where sampled lrck ≠ lrck_prev.
  - The sdata bit at this rise is the LAST bit of the ending slot.
  - The next rise carries the MSB of the new slot.
- bit_cnt counts bits received in the current slot and saturates at SLOT_W.
  - At a boundary, bits = bit_cnt+1 must equal SLOT_W; otherwise the slot is bad.
- Shift register captures slot bits 0..DATA_W-1 (MSB first). Bits DATA_W..SLOT_W-1 are ignored.
- FSM states:
  - IDLE: wait for a boundary where lrck goes 1→0 → LEFT. No samples are captured in IDLE.
  - LEFT: at the 0→1 boundary:
    - Good slot: left_hold ← shifter, → RIGHT.
    - Bad slot: frame_err←1, → IDLE.
  - RIGHT: at the 1→0 boundary:
    - Good slot: outputs update, sample_valid pulses, locked←1, → LEFT.
    - Bad slot: frame_err←1, locked←0, → IDLE; the pair is discarded.
- Output update:
  - exchangeLR=0: dsm_chan1←left_hold, dsm_chan2←right.
  - exchangeLR=1: the two are swapped.
  - exchangeLR is sampled on the update cycle only.
- Outputs hold between updates.
- Latency: sample_valid asserts SYNC_STAGES+2 mclk512 cycles after the first mclk512 edge that samples i2s_bclk high on the final right-slot bit.
- frame_err is sticky.
  - err_clr=1 clears it on the next edge.
  - Simultaneous set and clear → set wins.
- lrck toggling with no bclk edges: no state change.
- bclk running while lrck is static: bit_cnt saturates. The next boundary is flagged bad.

Decomposition:
- Package dsm_pkg holds:
  - DATA_W/SLOT_W defaults.
  - The FSM state enum (IDLE, LEFT, RIGHT).
  - The bit-counter width constant, $clog2(SLOT_W+1).
- One sub-module, dsm_sync_edge: SYNC_STAGES synchronizer plus rise detect. Instantiated for bclk; lrck and sdata use its plain sync output.

Test Plan:
- Nominal, 2 frames, L=24'h123456, R=24'hABCDEF, exchangeLR=0 → dsm_chan1=24'h123456, dsm_chan2=24'hABCDEF, one sample_valid per frame, locked=1, frame_err=0.
- Same stream with exchangeLR=1 → dsm_chan1=24'hABCDEF, dsm_chan2=24'h123456.
- Full-scale L=24'h800000, R=24'h7FFFFF with trailing 8 slot bits = 1 → outputs exactly 24'h800000 / 24'h7FFFFF; padding ignored.
- Right slot shortened to 31 bits → no sample_valid, frame_err=1, locked=0. Recovery on the next good pair with frame_err held until err_clr pulse, then frame_err=0.
- Stream starts mid-right slot → no sample_valid until one full left+right pair, first output correct.
- reset pulsed low mid-left slot → all outputs 0 immediately (async), IDLE; first sample_valid only after the next complete L+R pair.
